e203_dtcm_ram_ctrl: RTL and testbench
=====================================

Name: e203_dtcm_ram_ctrl

Overview:
Initiator-side controller for the DTCM SRAM macro. It converts an ICB-style command/response handshake into the macro's cs/we/addr/wem/din strobes and returns ram_dout as the read response. It also runs the macro's power pins (ls/ds/sd) from an idle-timer state machine. It sits between the core's DTCM ICB port and the RAM, and is the only block that drives the RAM pins.

Parameters:
AW, 14, RAM word-address width (byte address width = AW+2)
DW, 32, data width
MW, 4, write-mask width (DW/8)
LS_IDLE, 16, idle cycles in ACTIVE before entering light sleep
DS_IDLE, 256, idle cycles in LS before entering deep sleep
WAKE_CYC, 2, cycles spent in WAKE before accepting commands (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
icb_cmd_valid  in  1  command valid
icb_cmd_ready  out  1  command ready
icb_cmd_read  in  1  1=read, 0=write
icb_cmd_addr  in  AW+2  byte address
icb_cmd_wdata  in  DW  write data
icb_cmd_wmask  in  MW  byte enables
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  response ready
icb_rsp_rdata  out  DW  read data (0 for writes/errors)
icb_rsp_err  out  1  misaligned-access error
pwr_sd_req  in  1  shutdown request (level)
ctrl_busy  out  1  state!=ACTIVE or rsp_valid
ram_sd  out  1  shutdown
ram_ds  out  1  deep sleep
ram_ls  out  1  light sleep
ram_cs  out  1  chip select
ram_we  out  1  write enable
ram_addr  out  AW  word address
ram_wem  out  MW  write byte mask
ram_din  out  DW  write data
ram_dout  in  DW  read data, valid the cycle after a read cs and held while cs=0

Behaviour:
- Clock domain and reset: single clock clk; reset is synchronous, active-low on rst_n.
- Reset values: state=ACTIVE; idle/wake counters=0; rsp_valid=0; rsp_err=0; all ram_* outputs=0; icb_cmd_ready=1 after reset, given pwr_sd_req=0.
- Reset during a pending response drops that response. No RAM access is issued in the reset cycle.
- Handshake: accept = icb_cmd_valid & icb_cmd_ready.
- icb_cmd_ready = (state==ACTIVE) & ~pwr_sd_req & (~rsp_valid | icb_rsp_ready). This gives one outstanding access, with back-to-back accesses at full rate when icb_rsp_ready=1.
- RAM strobes are combinational from accept with an aligned address (addr[1:0]==0):
  - ram_cs=1, ram_we=~read, ram_addr=cmd_addr[AW+1:2]
  - ram_wem = read ? 0 : wmask; ram_din = read ? 0 : wdata
  - Otherwise ram_cs=ram_we=0 and ram_addr/wem/din=0.
- Misaligned command: accepted but no RAM access; the response has err=1 and rdata=0.
- Response latency: rsp_valid rises the cycle after accept. It holds until rsp_valid & icb_rsp_ready, then clears unless a new accept happens in the same cycle.
- Read rdata = ram_dout, passed through while rsp_valid. Stability is guaranteed because no cs occurs while a response is stalled. Write rdata=0.
- Write with wmask=0 still asserts cs/we with wem=0 and returns a normal response.
- Power FSM states: ACTIVE, LS, DS, SD, WAKE. Transition priority: pwr_sd_req > icb_cmd_valid > timers.
  - ACTIVE:
    - idle_cnt increments when no accept and rsp_valid=0; clears on accept or rsp_valid.
    - idle_cnt==LS_IDLE-1 with no pending cmd_valid -> LS.
    - pwr_sd_req & ~rsp_valid -> SD. With rsp pending, it waits for the rsp handshake; cmd_ready stays 0 meanwhile.
  - LS:
    - ram_ls=1, cmd_ready=0; idle_cnt restarts at 0.
    - cmd_valid -> WAKE.
    - idle_cnt==DS_IDLE-1 -> DS.
    - pwr_sd_req -> SD.
  - DS:
    - ram_ds=1, ram_ls=0.
    - cmd_valid -> WAKE; pwr_sd_req -> SD.
  - SD:
    - ram_sd=1, ram_ds=ram_ls=0; contents are lost.
    - pwr_sd_req=0 -> WAKE; cmd_valid is ignored.
  - WAKE:
    - All power pins 0, cmd_ready=0.
    - wake_cnt counts to WAKE_CYC-1, then -> ACTIVE with idle_cnt=0.
- Power pins are registered and one-hot-or-zero; ram_cs is never 1 outside ACTIVE.
- Counters saturate; widths are sized via $clog2 of their thresholds.

Test Plan:
- Write then read: write addr=0x0010, wdata=0xDEADBEEF, wmask=0xF. Expect ram_cs=1, we=1, ram_addr=0x0004, wem=0xF in the accept cycle and rsp next cycle err=0. Then a read of 0x0010 returns rdata=0xDEADBEEF 1 cycle after accept.
- Back-pressure: a read with icb_rsp_ready=0 for 3 cycles. Expect cmd_ready=0, ram_cs=0, and rsp_rdata stable across the stall. A second command is accepted in the cycle rsp_ready rises.
- Misaligned: write to addr=0x0013. Expect ram_cs=0 and a response with err=1, rdata=0.
- Idle entry: with no traffic for LS_IDLE=16 cycles, ram_ls=1. After DS_IDLE=256 more cycles, ram_ds=1, ram_ls=0. cmd_valid then gives WAKE for 2 cycles with cmd_ready=0, then accept.
- Shutdown: assert pwr_sd_req while a response is pending. SD is entered only after the rsp handshake, giving ram_sd=1. Deasserting gives WAKE then ACTIVE; cmd_valid asserted throughout SD is never accepted.
- Reset mid-op: rst_n=0 in the cycle after a read accept. Next cycle rsp_valid=0, all ram_* outputs=0, state=ACTIVE.

Source files
------------

// File: rtl/e203_dtcm_ram_ctrl.sv
// ---------------------------------------------------------------------------
// e203_dtcm_ram_ctrl
//   Initiator-side controller for the DTCM SRAM macro. Turns an ICB-style
//   command/response handshake into single-cycle RAM strobes and returns the
//   macro's read data as the response. It also sequences the macro power pins
//   (light sleep / deep sleep / shutdown) from idle timers.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   icb_cmd_*              command channel (valid/ready, read, byte addr,
//                          wdata, wmask)
//   icb_rsp_*              response channel (valid/ready, rdata, err)
//   pwr_sd_req             level shutdown request
//   ctrl_busy              not ACTIVE or a response is outstanding
//   ram_sd/ds/ls           registered, one-hot-or-zero power pins
//   ram_cs/we/addr/wem/din RAM access strobes (combinational from accept)
//   ram_dout               RAM read data, valid the cycle after a read cs
// ---------------------------------------------------------------------------
module e203_dtcm_ram_ctrl #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int LS_IDLE  = 16,
    parameter int DS_IDLE  = 256,
    parameter int WAKE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic          icb_cmd_read,
    input  logic [AW+1:0] icb_cmd_addr,
    input  logic [DW-1:0] icb_cmd_wdata,
    input  logic [MW-1:0] icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic [DW-1:0] icb_rsp_rdata,
    output logic          icb_rsp_err,
    input  logic          pwr_sd_req,
    output logic          ctrl_busy,
    output logic          ram_sd,
    output logic          ram_ds,
    output logic          ram_ls,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int IDLE_MAX = (LS_IDLE > DS_IDLE) ? LS_IDLE : DS_IDLE;
    localparam int IW       = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;
    localparam int WW       = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    localparam logic [IW-1:0] LS_LAST   = IW'(LS_IDLE - 1);
    localparam logic [IW-1:0] DS_LAST   = IW'(DS_IDLE - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_LS,
        ST_DS,
        ST_SD,
        ST_WAKE
    } pwr_state_e;

    pwr_state_e    state_q;
    logic [IW-1:0] idle_cnt_q;
    logic [WW-1:0] wake_cnt_q;
    logic          ram_ls_q, ram_ds_q, ram_sd_q;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_rd_q, rsp_rd_d;

    logic          cmd_ready;
    logic          accept;
    logic          aligned;
    logic          ram_acc;

    // Gating with rst_n keeps the reset cycle free of any RAM access even
    // though the strobes are combinational from the command inputs.
    assign cmd_ready = rst_n & (state_q == ST_ACTIVE) & ~pwr_sd_req
                     & (~rsp_valid_q | icb_rsp_ready);
    assign accept    = icb_cmd_valid & cmd_ready;
    assign aligned   = (icb_cmd_addr[1:0] == 2'b00);
    assign ram_acc   = accept & aligned;

    assign icb_cmd_ready = cmd_ready;
    assign ram_cs        = ram_acc;
    assign ram_we        = ram_acc & ~icb_cmd_read;
    assign ram_addr      = ram_acc ? icb_cmd_addr[AW+1:2] : '0;
    assign ram_wem       = (ram_acc & ~icb_cmd_read) ? icb_cmd_wmask : '0;
    assign ram_din       = (ram_acc & ~icb_cmd_read) ? icb_cmd_wdata : '0;

    assign ram_ls = ram_ls_q;
    assign ram_ds = ram_ds_q;
    assign ram_sd = ram_sd_q;

    // ram_dout is held by the macro while cs=0, and no cs can occur while a
    // response is stalled, so read data can be passed straight through.
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_err   = rsp_err_q;
    assign icb_rsp_rdata = (rsp_valid_q & rsp_rd_q) ? ram_dout : '0;
    assign ctrl_busy     = (state_q != ST_ACTIVE) | rsp_valid_q;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rd_d    = rsp_rd_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~aligned;
            rsp_rd_d    = icb_cmd_read & aligned;
        end else if (rsp_valid_q && icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    // Power FSM. Pins are updated together with the state so they always
    // reflect the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            ram_ls_q   <= 1'b0;
            ram_ds_q   <= 1'b0;
            ram_sd_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (pwr_sd_req && !rsp_valid_q) begin
                        state_q    <= ST_SD;
                        ram_sd_q   <= 1'b1;
                        idle_cnt_q <= '0;
                    end else if (accept || rsp_valid_q) begin
                        idle_cnt_q <= '0;
                    end else if (!icb_cmd_valid && idle_cnt_q == LS_LAST) begin
                        state_q    <= ST_LS;
                        ram_ls_q   <= 1'b1;
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                ST_LS: begin
                    if (pwr_sd_req) begin
                        state_q  <= ST_SD;
                        ram_ls_q <= 1'b0;
                        ram_sd_q <= 1'b1;
                    end else if (icb_cmd_valid) begin
                        state_q    <= ST_WAKE;
                        ram_ls_q   <= 1'b0;
                        wake_cnt_q <= '0;
                    end else if (idle_cnt_q == DS_LAST) begin
                        state_q  <= ST_DS;
                        ram_ls_q <= 1'b0;
                        ram_ds_q <= 1'b1;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                ST_DS: begin
                    if (pwr_sd_req) begin
                        state_q  <= ST_SD;
                        ram_ds_q <= 1'b0;
                        ram_sd_q <= 1'b1;
                    end else if (icb_cmd_valid) begin
                        state_q    <= ST_WAKE;
                        ram_ds_q   <= 1'b0;
                        wake_cnt_q <= '0;
                    end
                end
                ST_SD: begin
                    if (!pwr_sd_req) begin
                        state_q    <= ST_WAKE;
                        ram_sd_q   <= 1'b0;
                        wake_cnt_q <= '0;
                    end
                end
                ST_WAKE: begin
                    if (pwr_sd_req) begin
                        state_q  <= ST_SD;
                        ram_sd_q <= 1'b1;
                    end else if (wake_cnt_q == WAKE_LAST) begin
                        state_q    <= ST_ACTIVE;
                        idle_cnt_q <= '0;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_ACTIVE;
                    ram_ls_q <= 1'b0;
                    ram_ds_q <= 1'b0;
                    ram_sd_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
module tb_e203_dtcm_ram_ctrl;

    localparam int AW       = 14;
    localparam int DW       = 32;
    localparam int MW       = 4;
    localparam int LS_IDLE  = 16;
    localparam int DS_IDLE  = 256;
    localparam int WAKE_CYC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic          icb_cmd_read;
    logic [AW+1:0] icb_cmd_addr;
    logic [DW-1:0] icb_cmd_wdata;
    logic [MW-1:0] icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [DW-1:0] icb_rsp_rdata;
    logic          icb_rsp_err;
    logic          pwr_sd_req;
    logic          ctrl_busy;
    logic          ram_sd, ram_ds, ram_ls, ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    e203_dtcm_ram_ctrl #(
        .AW(AW), .DW(DW), .MW(MW),
        .LS_IDLE(LS_IDLE), .DS_IDLE(DS_IDLE), .WAKE_CYC(WAKE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .pwr_sd_req(pwr_sd_req), .ctrl_busy(ctrl_busy),
        .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // SRAM macro behaviour: dout updates only on a read cs and holds otherwise.
    bit [31:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram_mem[ram_addr[7:0]];
            end
        end
    end

    // Reference memory for the randomized test (words 64..79).
    bit [31:0] ref_mem [0:15];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_idle();
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b1;
        pwr_sd_req    = 1'b0;
    endtask

    task automatic drive_cmd(input logic rd, input logic [15:0] a,
                             input logic [31:0] wd, input logic [3:0] wm);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (3) cyc();
        rst_n = 1'b1;
        smp();
        checks++; if (icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", icb_rsp_valid); end
        checks++; if (icb_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", icb_rsp_err); end
        checks++; if ({ram_sd, ram_ds, ram_ls, ram_cs, ram_we, ram_addr, ram_wem, ram_din} !== '0)
            begin errors++; $display("FAIL reset_ram_pins: got %h want 0", {ram_sd, ram_ds, ram_ls, ram_cs, ram_we, ram_addr, ram_wem, ram_din}); end
        checks++; if (icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", icb_cmd_ready); end
        checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ctrl_busy); end
    endtask

    task automatic test_write_read();
        cyc(); drive_cmd(1'b0, 16'h0010, 32'hDEADBEEF, 4'hF); smp();
        checks++; if (icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", icb_cmd_ready); end
        checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL wr_cs_we: got %b%b want 11", ram_cs, ram_we); end
        checks++; if (ram_addr !== 14'h0004) begin errors++; $display("FAIL wr_addr: got %h want 0004", ram_addr); end
        checks++; if (ram_wem !== 4'hF || ram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wem_din: got %h/%h want f/deadbeef", ram_wem, ram_din); end
        cyc(); drive_cmd(1'b1, 16'h0010, 32'h0, 4'h0); smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== '0)
            begin errors++; $display("FAIL wr_rsp: got v%b e%b d%h want v1 e0 d0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata); end
        checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 14'h0004 || ram_wem !== 4'h0 || ram_din !== '0)
            begin errors++; $display("FAIL rd_strobes: got cs%b we%b a%h m%h d%h want cs1 we0 a4 m0 d0", ram_cs, ram_we, ram_addr, ram_wem, ram_din); end
        cyc(); icb_cmd_valid = 1'b0; smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hDEADBEEF || icb_rsp_err !== 1'b0)
            begin errors++; $display("FAIL rd_rsp: got v%b d%h e%b want v1 deadbeef e0", icb_rsp_valid, icb_rsp_rdata, icb_rsp_err); end
        cyc(); smp();
        checks++; if (icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_clear: got %b want 0", icb_rsp_valid); end
    endtask

    task automatic test_back_pressure();
        cyc(); drive_cmd(1'b1, 16'h0010, 32'h0, 4'h0); icb_rsp_ready = 1'b0; smp();
        checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL bp_first_cs: got %b want 1", ram_cs); end
        for (int i = 0; i < 3; i++) begin
            cyc(); drive_cmd(1'b0, 16'h0020, 32'h12345678, 4'h3); icb_rsp_ready = 1'b0; smp();
            checks++; if (icb_cmd_ready !== 1'b0 || ram_cs !== 1'b0)
                begin errors++; $display("FAIL bp_stall_%0d: got ready%b cs%b want 0 0", i, icb_cmd_ready, ram_cs); end
            checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hDEADBEEF)
                begin errors++; $display("FAIL bp_hold_%0d: got v%b d%h want v1 deadbeef", i, icb_rsp_valid, icb_rsp_rdata); end
        end
        cyc(); icb_rsp_ready = 1'b1; smp();
        checks++; if (icb_cmd_ready !== 1'b1 || ram_cs !== 1'b1 || ram_addr !== 14'h0008 || ram_wem !== 4'h3)
            begin errors++; $display("FAIL bp_release: got ready%b cs%b a%h m%h want 1 1 8 3", icb_cmd_ready, ram_cs, ram_addr, ram_wem); end
        cyc(); icb_cmd_valid = 1'b0; smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== '0 || icb_rsp_err !== 1'b0)
            begin errors++; $display("FAIL bp_second_rsp: got v%b d%h e%b want v1 d0 e0", icb_rsp_valid, icb_rsp_rdata, icb_rsp_err); end
        cyc(); smp();
    endtask

    task automatic test_misaligned();
        cyc(); drive_cmd(1'b0, 16'h0013, 32'hFFFFFFFF, 4'hF); smp();
        checks++; if (icb_cmd_ready !== 1'b1 || ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_wem !== 4'h0)
            begin errors++; $display("FAIL mis_wr_strobes: got ready%b cs%b we%b m%h want 1 0 0 0", icb_cmd_ready, ram_cs, ram_we, ram_wem); end
        cyc(); drive_cmd(1'b1, 16'h0012, 32'h0, 4'h0); smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1 || icb_rsp_rdata !== '0)
            begin errors++; $display("FAIL mis_wr_rsp: got v%b e%b d%h want v1 e1 d0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata); end
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL mis_rd_cs: got %b want 0", ram_cs); end
        cyc(); icb_cmd_valid = 1'b0; smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1 || icb_rsp_rdata !== '0)
            begin errors++; $display("FAIL mis_rd_rsp: got v%b e%b d%h want v1 e1 d0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata); end
        cyc(); smp();
        checks++; if (icb_rsp_valid !== 1'b0 || icb_rsp_err !== 1'b0)
            begin errors++; $display("FAIL mis_clear: got v%b e%b want 0 0", icb_rsp_valid, icb_rsp_err); end
        cyc(); drive_cmd(1'b1, 16'h0010, 32'h0, 4'h0); smp();
        cyc(); icb_cmd_valid = 1'b0; smp();
        checks++; if (icb_rsp_rdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL mis_no_write: got %h want deadbeef", icb_rsp_rdata); end
        cyc(); smp();
    endtask

    task automatic test_random();
        bit          pend = 1'b0;
        logic        exp_err = 1'b0;
        logic [31:0] exp_rdata = '0;
        int unsigned quiet = 0;
        for (int n = 0; n < 400; n++) begin
            logic        v, rd, exp_rdy, acc, exp_cs;
            int unsigned w, lo;
            logic [31:0] wd;
            logic [3:0]  wm;
            cyc();
            v  = ($urandom_range(0, 9) < 7) || (quiet >= 8);
            quiet = v ? 0 : quiet + 1;
            rd = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 15);
            lo = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            wd = $urandom;
            wm = 4'($urandom_range(0, 15));
            drive_cmd(rd, 16'(256 + w * 4 + lo), wd, wm);
            icb_cmd_valid = v;
            icb_rsp_ready = ($urandom_range(0, 3) != 0);
            smp();
            checks++; if (icb_rsp_valid !== pend) begin errors++; $display("FAIL rnd_rsp_valid @%0d: got %b want %b", n, icb_rsp_valid, pend); end
            if (pend) begin
                checks++; if (icb_rsp_err !== exp_err || icb_rsp_rdata !== exp_rdata)
                    begin errors++; $display("FAIL rnd_rsp_data @%0d: got e%b d%h want e%b d%h", n, icb_rsp_err, icb_rsp_rdata, exp_err, exp_rdata); end
            end
            exp_rdy = !pend || icb_rsp_ready;
            acc     = v && exp_rdy;
            exp_cs  = acc && (lo == 0);
            checks++; if (icb_cmd_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", n, icb_cmd_ready, exp_rdy); end
            checks++; if (ram_cs !== exp_cs) begin errors++; $display("FAIL rnd_cs @%0d: got %b want %b", n, ram_cs, exp_cs); end
            if (exp_cs) begin
                checks++; if (ram_addr !== 14'(64 + w) || ram_we !== !rd)
                    begin errors++; $display("FAIL rnd_addr_we @%0d: got a%h we%b want a%h we%b", n, ram_addr, ram_we, 14'(64 + w), !rd); end
            end
            if (acc) begin
                pend      = 1'b1;
                exp_err   = (lo != 0);
                exp_rdata = (rd && lo == 0) ? ref_mem[w] : 32'h0;
                if (!rd && lo == 0)
                    for (int b = 0; b < 4; b++)
                        if (wm[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end else if (pend && icb_rsp_ready) begin
                pend = 1'b0;
            end
        end
        cyc(); icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1; smp();
        cyc(); smp();
        checks++; if (icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b want 0", icb_rsp_valid); end
    endtask

    task automatic test_idle_sleep();
        int ls_at = -1;
        int ds_at = -1;
        int overlap = 0;
        cyc(); drive_cmd(1'b0, 16'h0030, 32'hA5A5A5A5, 4'hF); icb_rsp_ready = 1'b1; smp();
        checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL idle_seed_cs: got %b want 1", ram_cs); end
        cyc(); icb_cmd_valid = 1'b0; smp();
        // Cycle 0 below is the first with no accept and no response pending.
        for (int i = 0; i < 280; i++) begin
            cyc(); smp();
            if (ram_ls && ls_at < 0) ls_at = i;
            if (ram_ds && ds_at < 0) ds_at = i;
            if (ram_ls && ram_ds) overlap++;
        end
        checks++; if (ls_at != LS_IDLE) begin errors++; $display("FAIL ls_entry: got %0d want %0d", ls_at, LS_IDLE); end
        checks++; if (ds_at != LS_IDLE + DS_IDLE) begin errors++; $display("FAIL ds_entry: got %0d want %0d", ds_at, LS_IDLE + DS_IDLE); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL ls_ds_onehot: got %0d want 0", overlap); end
        checks++; if (ram_ds !== 1'b1 || ram_ls !== 1'b0 || icb_cmd_ready !== 1'b0 || ctrl_busy !== 1'b1)
            begin errors++; $display("FAIL ds_state: got ds%b ls%b ready%b busy%b want 1 0 0 1", ram_ds, ram_ls, icb_cmd_ready, ctrl_busy); end
        cyc(); drive_cmd(1'b1, 16'h0010, 32'h0, 4'h0); smp();
        checks++; if (icb_cmd_ready !== 1'b0 || ram_cs !== 1'b0 || ram_ds !== 1'b1)
            begin errors++; $display("FAIL wake_req: got ready%b cs%b ds%b want 0 0 1", icb_cmd_ready, ram_cs, ram_ds); end
        for (int i = 0; i < WAKE_CYC; i++) begin
            cyc(); smp();
            checks++; if (icb_cmd_ready !== 1'b0 || ram_cs !== 1'b0 || {ram_sd, ram_ds, ram_ls} !== 3'b000)
                begin errors++; $display("FAIL wake_%0d: got ready%b cs%b pins%b want 0 0 000", i, icb_cmd_ready, ram_cs, {ram_sd, ram_ds, ram_ls}); end
        end
        cyc(); smp();
        checks++; if (icb_cmd_ready !== 1'b1 || ram_cs !== 1'b1)
            begin errors++; $display("FAIL wake_accept: got ready%b cs%b want 1 1", icb_cmd_ready, ram_cs); end
        cyc(); icb_cmd_valid = 1'b0; smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL wake_rdata: got v%b d%h want v1 deadbeef", icb_rsp_valid, icb_rsp_rdata); end
        cyc(); smp();
    endtask

    task automatic test_shutdown();
        int sd_accepts = 0;
        cyc(); drive_cmd(1'b1, 16'h0030, 32'h0, 4'h0); icb_rsp_ready = 1'b0; smp();
        checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL sd_first_cs: got %b want 1", ram_cs); end
        cyc(); drive_cmd(1'b1, 16'h0010, 32'h0, 4'h0); pwr_sd_req = 1'b1; smp();
        checks++; if (icb_cmd_ready !== 1'b0 || ram_cs !== 1'b0 || ram_sd !== 1'b0 || icb_rsp_rdata !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL sd_pending: got ready%b cs%b sd%b d%h want 0 0 0 a5a5a5a5", icb_cmd_ready, ram_cs, ram_sd, icb_rsp_rdata); end
        cyc(); smp();
        checks++; if (ram_sd !== 1'b0 || icb_rsp_valid !== 1'b1)
            begin errors++; $display("FAIL sd_wait: got sd%b v%b want 0 1", ram_sd, icb_rsp_valid); end
        cyc(); icb_rsp_ready = 1'b1; smp();
        checks++; if (icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL sd_hs_ready: got %b want 0", icb_cmd_ready); end
        cyc(); smp();
        checks++; if (icb_rsp_valid !== 1'b0 || ram_sd !== 1'b0)
            begin errors++; $display("FAIL sd_after_hs: got v%b sd%b want 0 0", icb_rsp_valid, ram_sd); end
        cyc(); smp();
        checks++; if (ram_sd !== 1'b1 || ram_ds !== 1'b0 || ram_ls !== 1'b0)
            begin errors++; $display("FAIL sd_enter: got sd%b ds%b ls%b want 1 0 0", ram_sd, ram_ds, ram_ls); end
        for (int i = 0; i < 5; i++) begin
            cyc(); smp();
            if (icb_cmd_ready || ram_cs || !ram_sd) sd_accepts++;
        end
        checks++; if (sd_accepts != 0) begin errors++; $display("FAIL sd_hold: got %0d bad cycles want 0", sd_accepts); end
        cyc(); pwr_sd_req = 1'b0; smp();
        checks++; if (ram_sd !== 1'b1 || icb_cmd_ready !== 1'b0)
            begin errors++; $display("FAIL sd_release: got sd%b ready%b want 1 0", ram_sd, icb_cmd_ready); end
        cyc(); smp();
        checks++; if (ram_sd !== 1'b0 || icb_cmd_ready !== 1'b0)
            begin errors++; $display("FAIL sd_wake0: got sd%b ready%b want 0 0", ram_sd, icb_cmd_ready); end
        cyc(); smp();
        checks++; if (icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL sd_wake1: got %b want 0", icb_cmd_ready); end
        cyc(); smp();
        checks++; if (icb_cmd_ready !== 1'b1 || ram_cs !== 1'b1)
            begin errors++; $display("FAIL sd_resume: got ready%b cs%b want 1 1", icb_cmd_ready, ram_cs); end
        cyc(); icb_cmd_valid = 1'b0; smp();
        checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0)
            begin errors++; $display("FAIL sd_resume_rsp: got v%b e%b want 1 0", icb_rsp_valid, icb_rsp_err); end
        cyc(); smp();
    endtask

    task automatic test_reset_midop();
        cyc(); drive_cmd(1'b1, 16'h0010, 32'h0, 4'h0); icb_rsp_ready = 1'b0; smp();
        checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL rmid_cs: got %b want 1", ram_cs); end
        cyc(); rst_n = 1'b0; drive_cmd(1'b1, 16'h0030, 32'h0, 4'h0); smp();
        checks++; if (ram_cs !== 1'b0 || icb_cmd_ready !== 1'b0)
            begin errors++; $display("FAIL rmid_no_access: got cs%b ready%b want 0 0", ram_cs, icb_cmd_ready); end
        cyc(); rst_n = 1'b1; icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1; smp();
        checks++; if (icb_rsp_valid !== 1'b0 || icb_rsp_err !== 1'b0)
            begin errors++; $display("FAIL rmid_rsp: got v%b e%b want 0 0", icb_rsp_valid, icb_rsp_err); end
        checks++; if ({ram_sd, ram_ds, ram_ls, ram_cs, ram_we, ram_addr, ram_wem, ram_din} !== '0)
            begin errors++; $display("FAIL rmid_ram_pins: got %h want 0", {ram_sd, ram_ds, ram_ls, ram_cs, ram_we, ram_addr, ram_wem, ram_din}); end
        checks++; if (icb_cmd_ready !== 1'b1 || ctrl_busy !== 1'b0)
            begin errors++; $display("FAIL rmid_active: got ready%b busy%b want 1 0", icb_cmd_ready, ctrl_busy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_write_read();
        test_back_pressure();
        test_misaligned();
        test_random();
        test_idle_sleep();
        test_shutdown();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
